count_ctrl: RTL and testbench
=============================

# count_ctrl

Sequencer for the up/down counter datapath: it drives the counter's enable, direction and load controls to run a programmable ping-pong sweep between a lower and an upper limit, repeated for a requested number of round trips. It sits beside the 8/16-bit counter instances and replaces the free-running `direction` pin with a start/stop controlled sweep engine. The counter's current value is fed back so the controller can stop it exactly on each limit.

## Interface
- `WIDTH`, 8: counter and limit width.
- `HOLD_CYCLES`, 4: dwell cycles at each limit. Only used when `COUNT_CTRL_HOLD_EN` is defined. Legal range 1..255.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run. Sampled only in IDLE.
- `stop` in 1: abort the run. Honoured in any non-IDLE state.
- `lo_lim` in WIDTH: lower limit. Latched on an accepted `start`.
- `hi_lim` in WIDTH: upper limit. Latched on an accepted `start`.
- `num_sweeps` in 8: number of round trips to run. 0 means run continuously until `stop`. Latched on an accepted `start`.
- `count_in` in WIDTH: current counter value.
- `cnt_en` out 1: counter step enable. Combinational, per the Operation rules.
- `cnt_dir` out 1: counter direction, 1 = up. Registered.
- `cnt_load` out 1: one-cycle pulse that loads `cnt_load_val` into the counter.
- `cnt_load_val` out WIDTH: load value. Equals the latched `lo_lim`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a run completes normally.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.
- `sweep_cnt` out 8: number of round trips completed in the current run.

## Operation
- **States:** IDLE, LOAD, UP, DOWN, HOLD_HI, HOLD_LO, DONE. HOLD_HI and HOLD_LO exist only when the macro is defined.
- **Reset values:**
  - State IDLE.
  - `cnt_dir` = 1.
  - `cnt_en`, `cnt_load`, `busy`, `done`, `cfg_err` = 0.
  - `sweep_cnt` = 0.
  - Latched limits = 0.
- **IDLE:**
  - `start` with `lo_lim < hi_lim`: latch the configuration, clear `sweep_cnt`, go to LOAD.
  - `start` with `lo_lim >= hi_lim`: pulse `cfg_err` next cycle and stay in IDLE.
- **LOAD:** assert `cnt_load` for one cycle, set `cnt_dir` = 1, go to UP.
- **UP:**
  - `cnt_en` = 1 while `count_in != hi_lim`.
  - When `count_in == hi_lim`: `cnt_en` = 0 and the state leaves UP.
  - Next state is HOLD_HI if the macro is defined. Otherwise go to DOWN with `cnt_dir` = 0.
- **DOWN:**
  - `cnt_en` = 1 while `count_in != lo_lim`.
  - When `count_in == lo_lim`: `cnt_en` = 0 and `sweep_cnt` increments.
  - If `num_sweeps != 0` and the new `sweep_cnt == num_sweeps`, go to DONE.
  - Otherwise go to HOLD_LO (macro defined) or to UP with `cnt_dir` = 1.
- **DONE:** `done` = 1 for one cycle, then go to IDLE. `busy` stays high during DONE.
- **`stop`:**
  - In any non-IDLE state: next state IDLE, `cnt_en` is forced to 0 in that same cycle, no `done` pulse.
  - `sweep_cnt` holds its value until the next accepted `start`.
- **Reset** in any state, including mid-sweep, returns all outputs to their reset values on the next edge.
- **Counter overrun:** `count_in` outside the latched limits, e.g. an external disturbance, is not corrected. The controller keeps stepping in the current direction until the value equals the limit, wrapping modulo 2^WIDTH.
- **Continuous mode:** with `num_sweeps == 0`, `sweep_cnt` wraps from 255 to 0.

## Timing
- **Start latency:** `start` sampled in cycle 0, LOAD in cycle 1, first `cnt_en` in cycle 2.
- **Turn-around:** without the macro, the limit-hit cycle has `cnt_en` = 0 and reversed counting begins on the next cycle. Each turn-around therefore costs exactly 1 idle cycle.
- **Dwell:** with the macro, the limit-hit cycle is followed by exactly `HOLD_CYCLES` cycles of HOLD, then counting resumes in the new direction.
- **Worked example**, `lo` = 2, `hi` = 5, `num_sweeps` = 1, no macro:
  - `cnt_en` high in cycles 2–4.
  - Limit hit (count 5) in cycle 5.
  - `cnt_dir` = 0 from cycle 6, `cnt_en` high in cycles 6–8.
  - Lower limit hit in cycle 9.
  - `done` in cycle 10.
  - IDLE and `busy` = 0 in cycle 11.
- **`stop` vs `done`:** if `stop` and the last lower-limit hit occur in the same cycle, `stop` wins: IDLE, no `done`, but `sweep_cnt` still increments.

## Configuration
- **`COUNT_CTRL_HOLD_EN` defined:** HOLD_HI and HOLD_LO states plus a dwell timer. The counter pauses for `HOLD_CYCLES` cycles at each limit. `stop` during HOLD aborts immediately.
- **Not defined:** no hold states, no timer logic, `HOLD_CYCLES` is ignored, and direction reverses with a single idle cycle.

## Structure
- **Shared package `count_ctrl_pkg`:**
  - State enum `count_ctrl_state_t`.
  - Direction constants `DIR_UP` = 1, `DIR_DOWN` = 0.
  - Sweep-count width constant `SWEEP_W` = 8.
- **Sub-module `count_ctrl_hold_timer`:** load / terminal-count down-counter for the dwell. Instantiated only under `COUNT_CTRL_HOLD_EN`.

## Test plan
- **Basic run:** `lo` = 2, `hi` = 5, `num_sweeps` = 1, no macro → `cnt_en` pattern and `done` in cycle 10 exactly as in the worked example; `sweep_cnt` = 1.
- **Config error:** `start` with `lo` = 7, `hi` = 7 → `cfg_err` one-cycle pulse, `busy` stays 0, no `cnt_load`.
- **Mid-sweep stop:** `num_sweeps` = 0, `stop` in cycle 4 → `cnt_en` = 0 in cycle 4, IDLE in cycle 5, no `done`.
- **Dwell:** macro defined, `HOLD_CYCLES` = 3, `lo` = 0, `hi` = 3 → exactly 3 zero-enable cycles after each limit-hit cycle; `cnt_dir` flips on leaving HOLD.
- **Reset mid-run:** `reset` asserted during DOWN → next cycle all outputs at reset values; a following `start` runs normally.
- **Full-range wrap:** `WIDTH` = 8, `lo` = 0, `hi` = 255, `num_sweeps` = 3 → `sweep_cnt` reaches 3; the counter never leaves 0..255; `done` once.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl sweep sequencer.
// Hold states are present only when COUNT_CTRL_HOLD_EN is defined.
package count_ctrl_pkg;

    localparam int SWEEP_W = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

`ifdef COUNT_CTRL_HOLD_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_UP      = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_HI = 3'd4,
        ST_HOLD_LO = 3'd5,
        ST_DONE    = 3'd6
    } count_ctrl_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_UP      = 3'd2,
        ST_DOWN    = 3'd3,
        ST_DONE    = 3'd6
    } count_ctrl_state_t;
`endif

endpackage

// File: rtl/count_ctrl_hold_timer.sv
// Dwell timer: loaded on a limit hit, tc is high in the last of HOLD_CYCLES hold cycles.
// Only instantiated when COUNT_CTRL_HOLD_EN is defined.
module count_ctrl_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tc
);

    localparam logic [7:0] LOAD_VAL = 8'(HOLD_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == 8'd0);

endmodule

// File: rtl/count_ctrl.sv
// Ping-pong sweep sequencer driving an external up/down counter between latched limits.
// Define COUNT_CTRL_HOLD_EN to add a HOLD_CYCLES dwell at each limit.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   lo_lim,
    input  logic [WIDTH-1:0]   hi_lim,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [WIDTH-1:0]   count_in,
    output logic               cnt_en,
    output logic               cnt_dir,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_val,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    count_ctrl_state_t  state_q, state_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [SWEEP_W-1:0] num_q, num_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic               cfg_err_q, cfg_err_d;

`ifdef COUNT_CTRL_HOLD_EN
    logic hold_load;
    logic hold_tc;

    count_ctrl_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .tc    (hold_tc)
    );
`endif

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        num_d     = num_q;
        sweep_d   = sweep_q;
        cfg_err_d = 1'b0;
        cnt_en    = 1'b0;
`ifdef COUNT_CTRL_HOLD_EN
        hold_load = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (lo_lim < hi_lim) begin
                        lo_d    = lo_lim;
                        hi_d    = hi_lim;
                        num_d   = num_sweeps;
                        sweep_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                dir_d   = DIR_UP;
                state_d = ST_UP;
            end
            ST_UP: begin
                if (count_in != hi_q) begin
                    cnt_en = 1'b1;
                end else begin
`ifdef COUNT_CTRL_HOLD_EN
                    hold_load = 1'b1;
                    state_d   = ST_HOLD_HI;
`else
                    dir_d   = DIR_DOWN;
                    state_d = ST_DOWN;
`endif
                end
            end
            ST_DOWN: begin
                if (count_in != lo_q) begin
                    cnt_en = 1'b1;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                    if ((num_q != '0) && (sweep_d == num_q)) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef COUNT_CTRL_HOLD_EN
                        hold_load = 1'b1;
                        state_d   = ST_HOLD_LO;
`else
                        dir_d   = DIR_UP;
                        state_d = ST_UP;
`endif
                    end
                end
            end
`ifdef COUNT_CTRL_HOLD_EN
            ST_HOLD_HI: begin
                if (hold_tc) begin
                    dir_d   = DIR_DOWN;
                    state_d = ST_DOWN;
                end
            end
            ST_HOLD_LO: begin
                if (hold_tc) begin
                    dir_d   = DIR_UP;
                    state_d = ST_UP;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abort freezes direction; a coincident lower-limit hit still counts.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            dir_d   = dir_q;
            cnt_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            lo_q      <= '0;
            hi_q      <= '0;
            num_q     <= '0;
            sweep_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            num_q     <= num_d;
            sweep_q   <= sweep_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cnt_dir      = dir_q;
    assign cnt_load     = (state_q == ST_LOAD);
    assign cnt_load_val = lo_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign cfg_err      = cfg_err_q;
    assign sweep_cnt    = sweep_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Randomized bench for count_ctrl: a per-cycle expected trace is built from the sweep rules
// and compared against the DUT driving a simple up/down counter plant.
module tb_count_ctrl;

    localparam int WIDTH = 8;
    localparam int HC    = 3;
`ifdef COUNT_CTRL_HOLD_EN
    localparam int HOLD_N = HC;
`else
    localparam int HOLD_N = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] lo_lim = '0;
    logic [WIDTH-1:0] hi_lim = '0;
    logic [7:0]       num_sweeps = '0;
    logic [WIDTH-1:0] count_in = '0;
    logic             cnt_en, cnt_dir, cnt_load, busy, done, cfg_err;
    logic [WIDTH-1:0] cnt_load_val;
    logic [7:0]       sweep_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    count_ctrl #(.WIDTH(WIDTH), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .lo_lim(lo_lim), .hi_lim(hi_lim), .num_sweeps(num_sweeps),
        .count_in(count_in), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .busy(busy),
        .done(done), .cfg_err(cfg_err), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    // Counter plant fed by the controller outputs
    always @(posedge clk) begin
        if (cnt_load)
            count_in <= cnt_load_val;
        else if (cnt_en)
            count_in <= cnt_dir ? count_in + 1'b1 : count_in - 1'b1;
    end

    typedef struct {
        logic       en, load, dir, busy, done, lo_hit;
        logic [7:0] sw;
    } exp_t;

    exp_t       trace[$];
    logic       dir_m = 1'b1;
    logic [7:0] sw_m = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic en, input logic load, input logic dir, input logic bsy,
                        input logic dn, input logic lo_hit, input logic [7:0] sw);
        exp_t e;
        e.en = en; e.load = load; e.dir = dir; e.busy = bsy;
        e.done = dn; e.lo_hit = lo_hit; e.sw = sw;
        trace.push_back(e);
    endtask

    // Expected cycle-by-cycle behaviour of one run, cycle 0 being the start cycle
    task automatic build(input int lo, input int hi, input int n, input int n_build);
        int d = hi - lo;
        int sweeps = (n == 0) ? n_build : n;
        logic [7:0] sw = 8'd0;
        trace.delete();
        push(0, 0, dir_m, 0, 0, 0, sw_m);
        push(0, 1, dir_m, 1, 0, 0, sw);
        for (int s = 1; s <= sweeps; s++) begin
            for (int k = 0; k < d; k++) push(1, 0, 1, 1, 0, 0, sw);
            push(0, 0, 1, 1, 0, 0, sw);
            for (int k = 0; k < HOLD_N; k++) push(0, 0, 1, 1, 0, 0, sw);
            for (int k = 0; k < d; k++) push(1, 0, 0, 1, 0, 0, sw);
            push(0, 0, 0, 1, 0, 1, sw);
            sw = sw + 8'd1;
            if (n == 0 || s < n)
                for (int k = 0; k < HOLD_N; k++) push(0, 0, 0, 1, 0, 0, sw);
        end
        if (n != 0) begin
            push(0, 0, 0, 1, 1, 0, sw);
            push(0, 0, 0, 0, 0, 0, sw);
        end
    endtask

    // mode 0: plain run, 1: stop in cycle cut, 2: reset in cycle cut (cut -1 = last, -2 = random)
    task automatic run_case(input int lo, input int hi, input int n, input int n_build,
                            input int cut, input int mode);
        int c = cut;
        int nd = 0;
        exp_t e;
        build(lo, hi, n, n_build);
        if (mode != 0) begin
            if (c == -1) c = trace.size() - 1;
            if (c == -2) c = $urandom_range(2, trace.size() - 1);
            while (trace.size() > c + 1) void'(trace.pop_back());
            e = trace[c];
            if (mode == 1) begin
                trace[c].en = 1'b0;
                push(0, 0, e.dir, 0, 0, 0, e.sw + {7'd0, e.lo_hit});
            end else begin
                push(0, 0, 1, 0, 0, 0, 8'd0);
            end
        end
        for (int i = 0; i < trace.size(); i++) begin
            #1;
            start      = (i == 0);
            stop       = (mode == 1) && (i == c);
            reset      = (mode == 2) && (i == c);
            lo_lim     = WIDTH'(lo);
            hi_lim     = WIDTH'(hi);
            num_sweeps = 8'(n);
            @(negedge clk);
            chk("cnt_en",   {31'd0, cnt_en},   {31'd0, trace[i].en});
            chk("cnt_load", {31'd0, cnt_load}, {31'd0, trace[i].load});
            chk("cnt_dir",  {31'd0, cnt_dir},  {31'd0, trace[i].dir});
            chk("busy",     {31'd0, busy},     {31'd0, trace[i].busy});
            chk("done",     {31'd0, done},     {31'd0, trace[i].done});
            chk("cfg_err",  {31'd0, cfg_err},  32'd0);
            chk("sweep_cnt", {24'd0, sweep_cnt}, {24'd0, trace[i].sw});
            if (trace[i].done) nd++;
            if (i >= 2 && trace[i].busy && !trace[i].done)
                chk("cnt_in_range", {31'd0, (count_in >= WIDTH'(lo)) && (count_in <= WIDTH'(hi))}, 32'd1);
            @(posedge clk);
        end
        #1;
        start = 1'b0; stop = 1'b0; reset = 1'b0;
        if (mode == 0) chk("done_count", nd, (n != 0) ? 1 : 0);
        dir_m = trace[trace.size() - 1].dir;
        sw_m  = trace[trace.size() - 1].sw;
        $display("run lo=%0d hi=%0d n=%0d mode=%0d cycles=%0d sweep_cnt=%0d", lo, hi, n, mode,
                 trace.size(), sweep_cnt);
    endtask

    task automatic cfg_case(input int lo, input int hi);
        #1;
        start = 1'b1; lo_lim = WIDTH'(lo); hi_lim = WIDTH'(hi); num_sweeps = 8'd1;
        @(negedge clk);
        chk("cfg_busy0", {31'd0, busy}, 32'd0);
        chk("cfg_err0", {31'd0, cfg_err}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        chk("cfg_busy1", {31'd0, busy}, 32'd0);
        chk("cfg_no_load", {31'd0, cnt_load}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        chk("cfg_sweep_hold", {24'd0, sweep_cnt}, {24'd0, sw_m});
        @(posedge clk);
        $display("cfg lo=%0d hi=%0d cfg_err checked", lo, hi);
    endtask

    initial begin
        int lo, hi;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en",   {31'd0, cnt_en},   32'd0);
        chk("rst_dir",  {31'd0, cnt_dir},  32'd1);
        chk("rst_load", {31'd0, cnt_load}, 32'd0);
        chk("rst_busy", {31'd0, busy},     32'd0);
        chk("rst_done", {31'd0, done},     32'd0);
        chk("rst_cfg",  {31'd0, cfg_err},  32'd0);
        chk("rst_sw",   {24'd0, sweep_cnt}, 32'd0);
        chk("rst_lval", {24'd0, cnt_load_val}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);

        run_case(2, 5, 1, 0, 0, 0);
        cfg_case(7, 7);
        cfg_case(9, 3);
        run_case(2, 5, 0, 2, 4, 1);
        run_case(2, 5, 1, 0, 9 + 2 * HOLD_N, 1);
        run_case(1, 6, 0, 2, 8, 2);
        run_case(3, 4, 2, 0, 0, 0);
        run_case(0, 255, 3, 0, 0, 0);
        run_case(0, 1, 0, 257, -1, 1);
        for (int r = 0; r < 6; r++) begin
            lo = $urandom_range(0, 200);
            hi = lo + $urandom_range(1, 30);
            run_case(lo, hi, $urandom_range(1, 3), 0, 0, 0);
        end
        for (int r = 0; r < 4; r++) begin
            lo = $urandom_range(0, 220);
            hi = lo + $urandom_range(1, 20);
            run_case(lo, hi, $urandom_range(0, 2), 2, -2, 1 + (r % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
